nfu_2_accum: RTL and testbench

NFU_2_ACCUM -- requirements
Module: nfu_2_accum

---
 rtl/nfu_params.sv | 28 ++
 rtl/nfu_2_adder_tree.sv | 38 +++
 rtl/nfu_2_accum.sv | 93 +++++++++
 tb/tb_nfu_2_accum.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfu_params.sv
// rtl/nfu_params.sv - shared NFU widths and signed saturation helper
package nfu_params;

  localparam int NFU_BIT_WIDTH = 16;
  localparam int NFU_TN        = 16;
  localparam int NFU_TNXTN     = NFU_TN * NFU_TN;
  localparam int NFU_ACC_WIDTH = 32;

  // Clamp bounds of the signed BIT_WIDTH range, held at accumulator width
  localparam logic signed [NFU_ACC_WIDTH-1:0] NFU_SAT_MAX =
    NFU_ACC_WIDTH'((1 <<< (NFU_BIT_WIDTH - 1)) - 1);
  localparam logic signed [NFU_ACC_WIDTH-1:0] NFU_SAT_MIN =
    NFU_ACC_WIDTH'(-NFU_SAT_MAX - 1);

  // Clamp an accumulator value into the signed output range
  function automatic logic [NFU_BIT_WIDTH-1:0] sat(
    input logic signed [NFU_ACC_WIDTH-1:0] v
  );
    if (v > NFU_SAT_MAX) begin
      return NFU_SAT_MAX[NFU_BIT_WIDTH-1:0];
    end
    if (v < NFU_SAT_MIN) begin
      return NFU_SAT_MIN[NFU_BIT_WIDTH-1:0];
    end
    return v[NFU_BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/nfu_2_adder_tree.sv
// rtl/nfu_2_adder_tree.sv - one row reduction of Tn signed products, registered
module nfu_2_adder_tree
  import nfu_params::*;
#(
  parameter int BIT_WIDTH = NFU_BIT_WIDTH,
  parameter int Tn        = NFU_TN,
  parameter int SUM_W     = BIT_WIDTH + $clog2(Tn)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic [BIT_WIDTH*Tn-1:0]    i_data,
  output logic signed [SUM_W-1:0]    o_sum
);

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] r_sum;

  // Full-precision sum: SUM_W bits cannot overflow for Tn operands
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < Tn; c++) begin
      w_sum = w_sum + SUM_W'($signed(i_data[c*BIT_WIDTH +: BIT_WIDTH]));
    end
  end

  // Stage A row-sum register; holds while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/nfu_2_accum.sv
// rtl/nfu_2_accum.sv - NFU-2: row reduction, cross-brick accumulation, saturation
module nfu_2_accum
  import nfu_params::*;
#(
  parameter int BIT_WIDTH = NFU_BIT_WIDTH,
  parameter int Tn        = NFU_TN,
  parameter int TnxTn     = NFU_TNXTN,
  parameter int ACC_WIDTH = NFU_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH*TnxTn-1:0] i_products,
  input  logic                       i_valid,
  input  logic                       i_last,
  output logic                       o_in_ready,
  output logic [BIT_WIDTH*Tn-1:0]    o_sums,
  output logic                       o_valid,
  input  logic                       i_out_ready
);

  localparam int SUM_W = BIT_WIDTH + $clog2(Tn);

  logic                          w_stall;
  logic                          r_valid_a;
  logic                          r_last_a;
  logic signed [SUM_W-1:0]       w_rowsum   [Tn];
  logic signed [ACC_WIDTH-1:0]   r_acc      [Tn];
  logic signed [ACC_WIDTH-1:0]   w_acc_next [Tn];
  logic [BIT_WIDTH*Tn-1:0]       r_sums;
  logic                          r_o_valid;

  // A held result with no taker freezes the whole pipe
  assign w_stall    = r_o_valid & ~i_out_ready;
  assign o_in_ready = ~w_stall;

  for (genvar r = 0; r < Tn; r++) begin : g_row
    nfu_2_adder_tree #(
      .BIT_WIDTH (BIT_WIDTH),
      .Tn        (Tn),
      .SUM_W     (SUM_W)
    ) u_tree (
      .clk    (clk),
      .rst    (rst),
      .i_en   (~w_stall),
      .i_data (i_products[r*Tn*BIT_WIDTH +: Tn*BIT_WIDTH]),
      .o_sum  (w_rowsum[r])
    );

    // Accumulator wraps; only the final output is clamped
    assign w_acc_next[r] = r_acc[r] + ACC_WIDTH'(w_rowsum[r]);
  end

  // Stage A control: tag the registered row sums with valid/last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_a <= 1'b0;
      r_last_a  <= 1'b0;
    end else if (!w_stall) begin
      r_valid_a <= i_valid;
      r_last_a  <= i_valid & i_last;
    end
  end

  // Stage B: accumulate, or emit the saturated group result and restart
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_sums    <= '0;
      for (int r = 0; r < Tn; r++) begin
        r_acc[r] <= '0;
      end
    end else if (!w_stall) begin
      if (r_valid_a && r_last_a) begin
        r_o_valid <= 1'b1;
        for (int r = 0; r < Tn; r++) begin
          r_sums[r*BIT_WIDTH +: BIT_WIDTH] <= sat(w_acc_next[r]);
          r_acc[r]                         <= '0;
        end
      end else begin
        r_o_valid <= 1'b0;
        if (r_valid_a) begin
          for (int r = 0; r < Tn; r++) begin
            r_acc[r] <= w_acc_next[r];
          end
        end
      end
    end
  end

  assign o_sums  = r_sums;
  assign o_valid = r_o_valid;

endmodule

// File: tb/tb_nfu_2_accum.sv
// tb/tb_nfu_2_accum.sv - directed self-checking bench for nfu_2_accum
module tb_nfu_2_accum;

  localparam int BW = 16;
  localparam int TN = 16;
  localparam int TT = 256;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [BW*TT-1:0]  i_products;
  logic              i_valid;
  logic              i_last;
  logic              o_in_ready;
  logic [BW*TN-1:0]  o_sums;
  logic              o_valid;
  logic              i_out_ready;

  nfu_2_accum #(
    .BIT_WIDTH (BW),
    .Tn        (TN),
    .TnxTn     (TT),
    .ACC_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_products  (i_products),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_in_ready  (o_in_ready),
    .o_sums      (o_sums),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int prod;
    int exp;
  } vec_t;
  vec_t vecs[13];

  // stream description
  int s_val[8];
  bit s_row[8];
  bit s_last[8];
  int n_in;
  int e_val[8];
  bit e_row[8];
  int n_out;
  bit rdy_pat[32];
  bit vld_pat[32];
  int first_c;
  int last_c;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BW*TT-1:0] build(input int v, input bit rowmode);
    logic [BW*TT-1:0] p;
    p = '0;
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) begin
        p[(r*TN+c)*BW +: BW] = BW'(rowmode ? r * v : v);
      end
    end
    return p;
  endfunction

  task automatic chk_lanes(input string name, input int e, input bit rowmode);
    int bad;
    int ex;
    bad = -1;
    for (int r = 0; r < TN; r++) begin
      ex = rowmode ? r * e : e;
      if (bad < 0 && int'($signed(o_sums[r*BW +: BW])) != ex) bad = r;
    end
    if (bad < 0) bad = TN - 1;
    ex = rowmode ? bad * e : e;
    chk($sformatf("%s_lane%0d", name, bad), $signed(o_sums[bad*BW +: BW]), ex);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pats();
    for (int i = 0; i < 32; i++) begin
      rdy_pat[i] = 1'b1;
      vld_pat[i] = 1'b1;
    end
  endtask

  task automatic run_stream(input string name);
    int idx;
    int oidx;
    bit prev_stall;
    logic [BW*TN-1:0] prev_sums;
    logic [AW-1:0] prev_acc;
    idx = 0;
    oidx = 0;
    prev_stall = 1'b0;
    prev_sums = '0;
    prev_acc = '0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 100 && (oidx < n_out || idx < n_in); c++) begin
      i_out_ready = (c < 32) ? rdy_pat[c] : 1'b1;
      i_valid = (idx < n_in) && ((c < 32) ? vld_pat[c] : 1'b1);
      if (idx < n_in) begin
        i_products = build(s_val[idx], s_row[idx]);
        i_last = s_last[idx];
      end else begin
        i_last = 1'b0;
      end
      #1;
      if (o_valid && !i_out_ready) begin
        chk({name, "_in_ready_stalled"}, o_in_ready, 0);
        if (prev_stall) begin
          chk({name, "_sums_frozen"}, o_sums == prev_sums, 1);
          chk({name, "_acc_frozen"}, dut.r_acc[0] == prev_acc, 1);
        end
      end
      prev_stall = o_valid && !i_out_ready;
      prev_sums = o_sums;
      prev_acc = dut.r_acc[0];
      if (o_valid && i_out_ready) begin
        if (oidx < n_out) chk_lanes($sformatf("%s_out%0d", name, oidx), e_val[oidx], e_row[oidx]);
        if (first_c < 0) first_c = c;
        last_c = c;
        oidx++;
      end
      if (i_valid && o_in_ready) idx++;
      step();
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    i_out_ready = 1'b1;
    chk({name, "_outputs_seen"}, oidx, n_out);
    chk({name, "_accepted"}, idx, n_in);
    chk({name, "_idle_after"}, o_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 16};
    vecs[1]  = '{32767, 32767};
    vecs[2]  = '{32767, 32767};
    vecs[3]  = '{32767, 32767};
    vecs[4]  = '{32767, 32767};
    vecs[5]  = '{-32768, -32768};
    vecs[6]  = '{-32768, -32768};
    vecs[7]  = '{-32768, -32768};
    vecs[8]  = '{-32768, -32768};
    vecs[9]  = '{2047, 32752};
    vecs[10] = '{2048, 32767};
    vecs[11] = '{-2048, -32768};
    vecs[12] = '{-1, -16};

    rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_out_ready = 1'b1;
    i_products = '0;
    clear_pats();
    step();
    i_products = build(7, 0);
    i_valid = 1'b1;
    i_last = 1'b1;
    step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_o_sums", o_sums == '0, 1);
    chk("rst_acc", dut.r_acc[3], 0);
    chk("rst_valid_a", dut.r_valid_a, 0);
    i_valid = 1'b0;
    i_last = 1'b0;
    rst = 1'b0;
    step();

    // single-brick groups: latency, saturation, drop after accept
    for (int i = 0; i < 13; i++) begin
      i_products = build(vecs[i].prod, 0);
      i_valid = 1'b1;
      i_last = 1'b1;
      step();
      i_valid = 1'b0;
      i_last = 1'b0;
      chk($sformatf("vec%0d_t1_valid", i), o_valid, 0);
      step();
      chk($sformatf("vec%0d_t2_valid", i), o_valid, 1);
      chk_lanes($sformatf("vec%0d", i), vecs[i].exp, 0);
      step();
      chk($sformatf("vec%0d_t3_valid", i), o_valid, 0);
    end

    // three bricks, row r = r, with idle cycles inside the group
    clear_pats();
    vld_pat[1] = 1'b0;
    vld_pat[2] = 1'b0;
    n_in = 3;
    for (int i = 0; i < 3; i++) begin
      s_val[i] = 1;
      s_row[i] = 1'b1;
      s_last[i] = (i == 2);
    end
    n_out = 1;
    e_val[0] = 48;
    e_row[0] = 1'b1;
    run_stream("rows3");
    begin
      int nz;
      nz = 0;
      for (int r = 0; r < TN; r++) if (dut.r_acc[r] != 0) nz++;
      chk("rows3_acc_cleared", nz, 0);
    end

    // downstream stall of 5 cycles while bricks keep coming
    clear_pats();
    for (int i = 0; i < 7; i++) rdy_pat[i] = 1'b0;
    n_in = 4;
    s_val[0] = 1; s_row[0] = 1'b0; s_last[0] = 1'b1;
    s_val[1] = 2; s_row[1] = 1'b0; s_last[1] = 1'b0;
    s_val[2] = 3; s_row[2] = 1'b0; s_last[2] = 1'b1;
    s_val[3] = 4; s_row[3] = 1'b0; s_last[3] = 1'b1;
    n_out = 3;
    e_val[0] = 16; e_row[0] = 1'b0;
    e_val[1] = 80; e_row[1] = 1'b0;
    e_val[2] = 64; e_row[2] = 1'b0;
    run_stream("stall");
    chk("stall_first_out_cycle", first_c, 7);

    // back-to-back last bricks: one result per cycle, no bubble
    clear_pats();
    n_in = 4;
    n_out = 4;
    for (int i = 0; i < 4; i++) begin
      s_val[i] = 5 + i;
      s_row[i] = 1'b0;
      s_last[i] = 1'b1;
      e_val[i] = 16 * (5 + i);
      e_row[i] = 1'b0;
    end
    run_stream("b2b");
    chk("b2b_first_cycle", first_c, 2);
    chk("b2b_contiguous", last_c - first_c, 3);

    // reset in the middle of a group discards partial sums
    i_products = build(5, 0);
    i_valid = 1'b1;
    i_last = 1'b0;
    step();
    step();
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_acc", dut.r_acc[0], 0);
    chk("midrst_valid_a", dut.r_valid_a, 0);
    clear_pats();
    n_in = 1;
    s_val[0] = 2; s_row[0] = 1'b0; s_last[0] = 1'b1;
    n_out = 1;
    e_val[0] = 32; e_row[0] = 1'b0;
    run_stream("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
